// File: rtl/md_seq_unit_pkg.sv
// Shared definitions for the MD sequencer: op encoding, FSM states, latencies.
// MADD/MADDU/MSUB/MSUBU are only recognised when MD_MADD_EN is defined.
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // How the pending result is folded into HI/LO at commit time.
  typedef enum logic [1:0] {
    PEND_SET  = 2'd0,
    PEND_ADD  = 2'd1,
    PEND_SUB  = 2'd2,
    PEND_KEEP = 2'd3
  } pend_mode_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;

  function automatic logic is_mul_class(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_long_op(input logic [3:0] op);
    return is_mul_class(op) || is_div_class(op);
  endfunction

  function automatic pend_mode_e pend_mode_of(input logic [3:0] op);
    pend_mode_e m;
    m = PEND_SET;
    if ((op == MD_MADD) || (op == MD_MADDU)) m = PEND_ADD;
    if ((op == MD_MSUB) || (op == MD_MSUBU)) m = PEND_SUB;
    return m;
  endfunction

endpackage

// File: rtl/md_seq_unit_calc.sv
// Combinational MD datapath: 64-bit product or {remainder, quotient}.
// Signed division is done on magnitudes so INT_MIN / -1 wraps cleanly.
module md_calc
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);

    // Low 64 bits of the extended product are exact for both signednesses.
    a_ext = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;

    neg_a  = signed_op & a[31];
    neg_b  = signed_op & b[31];
    a_mag  = neg_a ? (~a + 32'd1) : a;
    b_mag  = neg_b ? (~b + 32'd1) : b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem    = neg_a ? (~r_mag + 32'd1) : r_mag;

    div_by_zero = is_div_class(op) && (b == 32'd0);

    result = 64'd0;
    if (is_mul_class(op)) begin
      result = prod;
    end else if (is_div_class(op)) begin
      result = {rem, quot};
    end
  end

endmodule

// File: rtl/md_seq_unit.sv
// MD sequencer and HI/LO owner: fixed-latency MULT/DIV, MTHI/MTLO writes.
// Optional MADD/MSUB family enabled by defining MD_MADD_EN.
module md_seq_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        busy,
  output logic        hilo_busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [63:0]      pend_reg, pend_next;
  pend_mode_e       pend_mode_reg, pend_mode_next;

  logic [63:0]      calc_result;
  logic             calc_dbz;
  logic [63:0]      hilo_cur;
  logic [63:0]      hilo_new;

  md_calc u_calc (
    .op          (md_op),
    .a           (md_a),
    .b           (md_b),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      pend_reg      <= '0;
      pend_mode_reg <= PEND_SET;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      pend_reg      <= pend_next;
      pend_mode_reg <= pend_mode_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    pend_next      = pend_reg;
    pend_mode_next = pend_mode_reg;

    // Accumulating ops use HI/LO as they stand at the commit edge.
    hilo_cur = {hi_reg, lo_reg};
    case (pend_mode_reg)
      PEND_ADD:  hilo_new = hilo_cur + pend_reg;
      PEND_SUB:  hilo_new = hilo_cur - pend_reg;
      PEND_KEEP: hilo_new = hilo_cur;
      default:   hilo_new = pend_reg;
    endcase

    case (state_reg)
      ST_IDLE: begin
        if (md_start) begin
          if (is_long_op(md_op)) begin
            state_next     = ST_RUN;
            busy_next      = 1'b1;
            cnt_next       = is_div_class(md_op) ? DIV_LAT : MULT_LAT;
            pend_next      = calc_result;
            pend_mode_next = calc_dbz ? PEND_KEEP : pend_mode_of(md_op);
          end else if (md_op == MD_MTHI) begin
            hi_next = md_a;
          end else if (md_op == MD_MTLO) begin
            lo_next = md_a;
          end
        end
      end
      ST_RUN: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          cnt_next   = '0;
          hi_next    = hilo_new[63:32];
          lo_next    = hilo_new[31:0];
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign hilo_busy = busy_reg | (md_start & is_long_op(md_op));

`ifndef SYNTHESIS
  // A start while busy means the stall logic let something through.
  always @(posedge clk) begin
    if (reset && md_start) begin
      assert (!busy_reg)
      else $warning("md_start while busy: op %0d dropped", md_op);
    end
  end
`endif

endmodule
